// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock divider monitor:
//   - mon_state_t   : monitor FSM encoding (IDLE/ACQUIRE/MEASURE/LOCKED)
//   - RATIO_W_DEF   : default width of the programmed division ratio
//   - CNT_W_DEF     : default width of the period/high-time counters
//   - ratio_high_ok : accepts a high time of floor(N/2) or ceil(N/2)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int RATIO_W_DEF = 6;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_t;

    // Odd ratios may put the extra cycle in either phase, so both the floor
    // and the ceiling of N/2 are accepted as a healthy high time.
    function automatic logic ratio_high_ok(input logic [31:0] n,
                                           input logic [31:0] high);
        return (high == (n >> 1)) || (high == ((n + 32'd1) >> 1));
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// -----------------------------------------------------------------------------
// clk_edge_sync
// Samples an observed clock through SYNC_STAGES flops and produces registered
// rise/fall pulses plus a level that is aligned with those pulses.
// Ports:
//   clk       in   sampling clock
//   reset     in   asynchronous, active-low reset
//   async_in  in   observed signal
//   level     out  sampled level, aligned with rise/fall
//   rise      out  1-cycle pulse on a 0->1 transition of the sampled signal
//   fall      out  1-cycle pulse on a 1->0 transition of the sampled signal
// -----------------------------------------------------------------------------
module clk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    // prev_q updates on the same edge that registers rise/fall, so it shows
    // the new level in the same cycle the pulse is visible.
    assign level = prev_q;

endmodule

// File: rtl/clock_divider_monitor.sv
// -----------------------------------------------------------------------------
// clock_divider_monitor
// Measures period and high time of divided_clk in reference_clk cycles and
// checks them against the programmed division ratio N.
// Ports:
//   reference_clk       in   monitor clock
//   reset               in   asynchronous, active-low reset
//   clk_divider_enable  in   divider enable; monitor idles while 0
//   division_ratio      in   programmed ratio N (monitored for N >= 2)
//   divided_clk         in   divider output under observation
//   err_clear           in   1-cycle pulse clearing the sticky errors
//   measured_period     out  last completed period (rise to rise)
//   measured_high       out  high time of the last completed period
//   period_valid        out  1-cycle pulse when measured_* update
//   locked              out  LOCK_COUNT consecutive periods matched N
//   ratio_error         out  sticky: a checked period/high time mismatched
//   stuck_error         out  sticky: TIMEOUT cycles without a rising edge
//   fsm_state           out  current monitor state (mon_state_t encoding)
// Handshake: period_valid is a single-cycle strobe with no back-pressure;
// measured_*, locked and ratio_error are valid in the cycle it is high.
// -----------------------------------------------------------------------------
module clock_divider_monitor
    import clk_div_pkg::*;
#(
    parameter int RATIO_W     = RATIO_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic               reference_clk,
    input  logic               reset,
    input  logic               clk_divider_enable,
    input  logic [RATIO_W-1:0] division_ratio,
    input  logic               divided_clk,
    input  logic               err_clear,
    output logic [CNT_W-1:0]   measured_period,
    output logic [CNT_W-1:0]   measured_high,
    output logic               period_valid,
    output logic               locked,
    output logic               ratio_error,
    output logic               stuck_error,
    output logic [1:0]         fsm_state
);

    localparam int                 GOOD_W       = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0]  LOCK_TARGET  = GOOD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    // per_cnt is one behind the elapsed cycle count, so the timeout fires
    // when it holds TIMEOUT-1 and no edge arrives.
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    mon_state_t         state;
    logic [RATIO_W-1:0] ratio_q;
    logic [CNT_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   hi_cnt;
    logic [GOOD_W-1:0]  good_cnt;

    logic clk_level;
    logic clk_rise;
    logic clk_fall;
    logic unused_fall;

    clk_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (reference_clk),
        .reset    (reset),
        .async_in (divided_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    // The high time is counted from the level, the fall pulse is not needed.
    assign unused_fall = clk_fall;

    logic               run_ok;
    logic               ratio_changed;
    logic               timeout_hit;
    logic               tracking;
    logic [CNT_W-1:0]   per_inc;
    logic [CNT_W-1:0]   hi_inc;
    logic [GOOD_W-1:0]  good_inc;
    logic               period_ok;
    logic               ratio_set;
    logic               stuck_set;

    always_comb begin
        run_ok        = clk_divider_enable && (division_ratio >= RATIO_W'(2));
        ratio_changed = (division_ratio != ratio_q);
        timeout_hit   = (per_cnt >= TIMEOUT_LAST);
        tracking      = (state == ST_MEASURE) || (state == ST_LOCKED);
        per_inc       = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
        hi_inc        = (hi_cnt == CNT_MAX) ? CNT_MAX : hi_cnt + CNT_W'(1);
        good_inc      = (good_cnt >= LOCK_TARGET) ? LOCK_TARGET
                                                  : good_cnt + GOOD_W'(1);
        period_ok     = (per_inc == CNT_W'(ratio_q)) &&
                        ratio_high_ok(32'(ratio_q), 32'(hi_cnt));
        // A ratio change suppresses both the check and the timeout.
        ratio_set     = run_ok && tracking && !ratio_changed &&
                        clk_rise && !period_ok;
        stuck_set     = run_ok && (state != ST_IDLE) && !ratio_changed &&
                        !clk_rise && timeout_hit;
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            ratio_q         <= '0;
            per_cnt         <= '0;
            hi_cnt          <= '0;
            good_cnt        <= '0;
            measured_period <= '0;
            measured_high   <= '0;
            period_valid    <= 1'b0;
            locked          <= 1'b0;
            ratio_error     <= 1'b0;
            stuck_error     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            // A new error in the same cycle as err_clear keeps the flag set.
            ratio_error  <= ratio_set | (ratio_error & ~err_clear);
            stuck_error  <= stuck_set | (stuck_error & ~err_clear);

            if (!run_ok) begin
                state    <= ST_IDLE;
                per_cnt  <= '0;
                hi_cnt   <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (state == ST_IDLE) begin
                state    <= ST_ACQUIRE;
                ratio_q  <= division_ratio;
                per_cnt  <= '0;
                hi_cnt   <= '0;
                good_cnt <= '0;
            end else if (ratio_changed) begin
                state    <= ST_ACQUIRE;
                ratio_q  <= division_ratio;
                per_cnt  <= '0;
                hi_cnt   <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (clk_rise) begin
                // The rise cycle is already the first high cycle of the
                // new period, so the high counter restarts at 1.
                per_cnt <= '0;
                hi_cnt  <= CNT_W'(1);
                if (state == ST_ACQUIRE) begin
                    state    <= ST_MEASURE;
                    good_cnt <= '0;
                end else begin
                    measured_period <= per_inc;
                    measured_high   <= hi_cnt;
                    period_valid    <= 1'b1;
                    if (period_ok) begin
                        good_cnt <= good_inc;
                        if (good_inc >= LOCK_TARGET) begin
                            locked <= 1'b1;
                            state  <= ST_LOCKED;
                        end
                    end else begin
                        good_cnt <= '0;
                        locked   <= 1'b0;
                        state    <= ST_MEASURE;
                    end
                end
            end else if (timeout_hit) begin
                state    <= ST_ACQUIRE;
                per_cnt  <= '0;
                hi_cnt   <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                per_cnt <= per_inc;
                if (clk_level) begin
                    hi_cnt <= hi_inc;
                end
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_clock_divider_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_monitor
// Directed bench for clock_divider_monitor. Each completed divided_clk period
// pushes its expected report into exp_q; a monitor process pops one entry
// per period_valid strobe and compares.
// -----------------------------------------------------------------------------
module tb_clock_divider_monitor;

    logic       reference_clk;
    logic       reset;
    logic       clk_divider_enable;
    logic [5:0] division_ratio;
    logic       divided_clk;
    logic       err_clear;
    logic [7:0] measured_period;
    logic [7:0] measured_high;
    logic       period_valid;
    logic       locked;
    logic       ratio_error;
    logic       stuck_error;
    logic [1:0] fsm_state;

    clock_divider_monitor dut (
        .reference_clk      (reference_clk),
        .reset              (reset),
        .clk_divider_enable (clk_divider_enable),
        .division_ratio     (division_ratio),
        .divided_clk        (divided_clk),
        .err_clear          (err_clear),
        .measured_period    (measured_period),
        .measured_high      (measured_high),
        .period_valid       (period_valid),
        .locked             (locked),
        .ratio_error        (ratio_error),
        .stuck_error        (stuck_error),
        .fsm_state          (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial reference_clk = 1'b0;
    always #5 reference_clk = ~reference_clk;

    int cyc = 0;
    always @(posedge reference_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [18:0] exp_q[$];   // {period, high, locked, ratio_error, stuck_error}
    int   checks = 0;
    int   errors = 0;
    int   last_pv_cyc = 0;
    int   idle_viol = 0;
    logic watch_idle = 1'b0;

    // reference model of the checker state
    int   cur_n = 0;
    int   good_m = 0;
    logic acq = 1'b1;
    logic locked_m = 1'b0;
    logic rerr_m = 1'b0;
    logic stuck_m = 1'b0;
    int   prev_p = 0;
    int   prev_h = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [18:0] exp_v;
        logic [18:0] act_v;
        forever begin
            @(negedge reference_clk);
            if (watch_idle && fsm_state != 2'd0) idle_viol++;
            if (reset && period_valid) begin
                last_pv_cyc = cyc;
                act_v = {measured_period, measured_high, locked,
                         ratio_error, stuck_error};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_period_valid actual=%0h required=none",
                             act_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("period_report", 32'(act_v), 32'(exp_v));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge reference_clk);
            #1;
        end
    endtask

    task automatic toggle(input int p, input int h);
        divided_clk = 1'b1;
        wait_cyc(h);
        divided_clk = 1'b0;
        wait_cyc(p - h);
    endtask

    task automatic push_check(input int p, input int h);
        logic good;
        good = (p == cur_n) && ((h == cur_n / 2) || (h == (cur_n + 1) / 2));
        if (good) begin
            good_m = (good_m < 4) ? good_m + 1 : 4;
            if (good_m == 4) locked_m = 1'b1;
        end else begin
            rerr_m   = 1'b1;
            locked_m = 1'b0;
            good_m   = 0;
        end
        exp_q.push_back({8'(p), 8'(h), locked_m, rerr_m, stuck_m});
    endtask

    // Each rising edge completes the previous period unless it is the
    // acquisition edge.
    task automatic drive_cycle(input int p, input int h);
        if (!acq) push_check(prev_p, prev_h);
        acq    = 1'b0;
        prev_p = p;
        prev_h = h;
        toggle(p, h);
    endtask

    task automatic restart_model(input int n);
        cur_n    = n;
        acq      = 1'b1;
        good_m   = 0;
        locked_m = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset              = 1'b0;
        clk_divider_enable = 1'b0;
        division_ratio     = 6'd0;
        divided_clk        = 1'b0;
        err_clear          = 1'b0;
        fork
            monitor_loop();
        join_none

        wait_cyc(3);
        check("reset_outputs",
              32'({measured_period, measured_high, period_valid, locked,
                   ratio_error, stuck_error, fsm_state}), 32'd0);
        reset = 1'b1;
        wait_cyc(2);

        // enable low with activity, then N=1 with enable high: stays idle
        watch_idle     = 1'b1;
        division_ratio = 6'd5;
        repeat (3) toggle(5, 2);
        division_ratio     = 6'd1;
        clk_divider_enable = 1'b1;
        repeat (3) toggle(5, 2);
        wait_cyc(4);
        watch_idle = 1'b0;
        check("idle_no_exit", 32'(idle_viol), 32'd0);
        check("idle_outputs",
              32'({measured_period, measured_high, locked, ratio_error,
                   stuck_error}), 32'd0);
        clk_divider_enable = 1'b0;
        wait_cyc(2);

        // N=5 healthy divider: lock on the 4th check
        division_ratio = 6'd5;
        restart_model(5);
        clk_divider_enable = 1'b1;
        for (int i = 0; i < 6; i++) drive_cycle(5, (i % 2 == 0) ? 2 : 3);
        wait_cyc(4);
        check("lock_n5", 32'(locked), 32'd1);
        check("lock_n5_state", 32'(fsm_state), 32'd3);
        check("drain_n5", 32'(exp_q.size()), 32'd0);

        // ratio change 5 -> 3 while locked
        division_ratio = 6'd3;
        restart_model(3);
        wait_cyc(1);
        check("ratio_change_unlock", 32'(locked), 32'd0);
        check("ratio_change_acquire", 32'(fsm_state), 32'd1);
        for (int i = 0; i < 5; i++) drive_cycle(3, (i % 2 == 0) ? 1 : 2);
        wait_cyc(4);
        check("lock_n3", 32'(locked), 32'd1);
        check("no_error_n3", 32'(ratio_error), 32'd0);
        check("drain_n3", 32'(exp_q.size()), 32'd0);
        clk_divider_enable = 1'b0;
        wait_cyc(2);
        check("disable_idle", 32'({fsm_state, locked}), 32'd0);

        // period 4 while N=5: every check fails
        division_ratio = 6'd5;
        restart_model(5);
        clk_divider_enable = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(4, 2);
        wait_cyc(4);
        check("mismatch_error", 32'({ratio_error, locked}), 32'b10);
        clk_divider_enable = 1'b0;
        wait_cyc(3);
        check("error_sticky_idle", 32'(ratio_error), 32'd1);
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;
        rerr_m    = 1'b0;
        check("err_clear", 32'(ratio_error), 32'd0);
        check("drain_mismatch", 32'(exp_q.size()), 32'd0);

        // N=8 lock, then divided_clk stuck low
        division_ratio = 6'd8;
        restart_model(8);
        clk_divider_enable = 1'b1;
        for (int i = 0; i < 5; i++) drive_cycle(8, 4);
        for (int i = 0; i < 400 && !stuck_error; i++) wait_cyc(1);
        check("stuck_seen", 32'(stuck_error), 32'd1);
        check("stuck_latency", 32'(cyc - last_pv_cyc), 32'd255);
        check("stuck_unlock", 32'(locked), 32'd0);
        stuck_m = 1'b1;
        restart_model(8);
        clk_divider_enable = 1'b0;
        wait_cyc(2);
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;
        stuck_m   = 1'b0;
        check("stuck_clear", 32'(stuck_error), 32'd0);
        check("drain_stuck", 32'(exp_q.size()), 32'd0);

        // N=6, asynchronous reset in the middle of MEASURE
        division_ratio = 6'd6;
        restart_model(6);
        clk_divider_enable = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(6, 3);
        wait_cyc(4);
        check("pre_reset_measure", 32'(fsm_state), 32'd2);
        reset = 1'b0;
        #2;
        check("async_reset",
              32'({measured_period, measured_high, period_valid, locked,
                   ratio_error, stuck_error, fsm_state}), 32'd0);
        exp_q.delete();
        wait_cyc(2);
        reset = 1'b1;
        restart_model(6);
        wait_cyc(1);
        for (int i = 0; i < 5; i++) drive_cycle(6, 3);
        wait_cyc(4);
        check("relock_n6", 32'(locked), 32'd1);
        check("drain_final", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
